mult_seq: RTL
=============

// Module: mult_seq
//
// PURPOSE
//   Parametrised sequential shift-add multiplier, A_W x B_W -> A_W+B_W.
//   Retires one bit of b per clock, so area stays small at any operand width.
//   Sits between the colour/intensity registers and the PWM generators; scales
//   channel duty by master brightness.
//   Keeps the ld rising-edge / mult_rdy handshake of the 8x8 block. Adds a busy
//   flag, fixed parametrised latency and optional signed operands.
//
// PARAMETERS
//   A_W   8   width of operand a (multiplicand), >= 2
//   B_W   8   width of operand b (multiplier, iterated), >= 2; sets latency
//
// PORTS
//   clk       in   1        single clock, all logic on rising edge
//   reset     in   1        synchronous, active-high
//   ld        in   1        start request; only a 0->1 transition counts
//   a         in   A_W      multiplicand, sampled at the start edge only
//   b         in   B_W      multiplier, sampled at the start edge only
//   busy      out  1        computation in progress
//   mult_rdy  out  1        result valid / operation complete
//   result    out  A_W+B_W  product; holds until the next completion
//
// BEHAVIOUR
//   - Reset (clk edge with reset=1): result=0, mult_rdy=0, busy=0, state=IDLE,
//     cycle counter=0, ld_q=1.
//   - ld_q=1 at reset: ld held high through reset release does NOT start an
//     operation. ld must go low and then high again.
//   - ld_q <= ld every cycle. start = ld & ~ld_q & (state==IDLE).
//   - States:
//     - IDLE: on start, capture a/b, clear accumulator and counter, set busy=1,
//       mult_rdy=0, go to RUN.
//     - IDLE, no start: if ld=0 then mult_rdy <= 0. mult_rdy stays high while ld
//       is held high after completion.
//     - RUN: each cycle, if b_reg[0], acc += a_reg << cnt. Then b_reg >>= 1,
//       cnt++. When cnt == B_W-1, the final add is written straight to result,
//       mult_rdy=1, busy=0, go to IDLE.
//   - Latency: ld first sampled high at edge k -> result/mult_rdy valid after
//     edge k+B_W. Fixed; no early exit for zero operands.
//   - Accumulator width is A_W+B_W. The unsigned product cannot overflow, so no
//     saturation or wrap is needed.
//   - ld edges while busy are ignored, not queued. ld held high across
//     completion does not restart; a fresh 0->1 edge is required.
//   - a/b may change freely after the start edge without affecting the result.
//   - Start in the same cycle mult_rdy would be cleared: the start wins. The
//     capture already clears mult_rdy.
//   - Reset mid-operation: aborts immediately. All outputs return to reset
//     values; the partial result is discarded.
//   - result changes only at the completion edge (and on reset). It never shows
//     intermediate sums.
//
// CONFIGURATION
//   MULT_SIGNED_EN defined:
//     - a and b are two's complement; result is the two's-complement product.
//     - a_reg is sign-extended into the accumulator.
//     - The partial product for b's MSB (last RUN cycle) is subtracted, not
//       added.
//     - Latency unchanged.
//   MULT_SIGNED_EN undefined: operands and result unsigned (default build).
//
// TESTING
//   1. A_W=B_W=8, unsigned, a=255, b=255, ld 0->1 -> busy for 8 cycles;
//      result=16'hFE01, mult_rdy=1 after edge k+8.
//   2. a=0, b=0 -> result=0, latency still 8. Then a=1, b=200 -> result=16'd200.
//   3. ld held high through completion and 20 further cycles -> exactly one
//      operation; mult_rdy stays 1; clears one cycle after ld sampled 0.
//   4. Start a=3, b=5, pulse ld again at cycle 3 of RUN with a=7 -> second
//      edge ignored; result=15.
//   5. Reset asserted at RUN cycle 4 -> result=0, mult_rdy=0, busy=0 next edge.
//      ld high during release -> no start.
//   6. MULT_SIGNED_EN, 8x8: -128*-128 -> 16'h4000; -1*127 -> 16'hFF81.
//      A_W=12, B_W=4 unsigned: 4095*15 -> 16'd61425 after 4 cycles.

Source files
------------

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier, A_W x B_W -> A_W+B_W, one b bit per clock.
// Ports: clk, reset (sync, active-high), ld (rising-edge start), a, b,
//   busy, mult_rdy, result. Define MULT_SIGNED_EN for two's-complement operands.
module mult_seq #(
  parameter int A_W = 8,
  parameter int B_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               busy,
  output logic               mult_rdy,
  output logic [A_W+B_W-1:0] result
);

  localparam int P  = A_W + B_W;
  localparam int CW = $clog2(B_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(B_W - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  state_t          state_d;
  logic            ld_q;
  logic [P-1:0]    a_reg;
  logic [P-1:0]    acc;
  logic [P-1:0]    pp;
  logic [P-1:0]    sum;
  logic [P-1:0]    a_ext;
  logic [B_W-1:0]  b_reg;
  logic [CW-1:0]   cnt;
  logic            start;
  logic            last;

`ifdef MULT_SIGNED_EN
  assign a_ext = {{B_W{a[A_W-1]}}, a};
`else
  assign a_ext = {{B_W{1'b0}}, a};
`endif

  always_comb begin
    start   = ld & ~ld_q & (state == IDLE);
    last    = (cnt == CNT_LAST);
    pp      = b_reg[0] ? (a_reg << cnt) : '0;
`ifdef MULT_SIGNED_EN
    // b's MSB carries negative weight
    sum     = last ? (acc - pp) : (acc + pp);
`else
    sum     = acc + pp;
`endif
    state_d = state;
    unique case (state)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // ld_q=1 so ld held through reset release is not an edge
      ld_q     <= 1'b1;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      mult_rdy <= 1'b0;
      result   <= '0;
    end else begin
      ld_q <= ld;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= a_ext;
            b_reg    <= b;
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            mult_rdy <= 1'b0;
          end else if (!ld) begin
            mult_rdy <= 1'b0;
          end
        end
        RUN: begin
          acc   <= sum;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + CW'(1);
          if (last) begin
            result   <= sum;
            mult_rdy <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
